inv_sub_shift_serial: RTL
=========================

Name: inv_sub_shift_serial

Overview:
- Byte-serial AES decryption round stage: accepts a 128-bit state, applies InvShiftRows and InvSubBytes using a single inverse S-box instance, and returns the 128-bit result.
- Consumes the inverse S-box lookup and trades throughput (16 cycles/block) for area.
- Sits between the AddRoundKey/InvMixColumns stage and the round controller in the decryption datapath.
- Valid/ready handshake on both sides.

Parameters:
SHIFT_EN, 1, 1 = apply InvShiftRows during byte placement; 0 = InvSubBytes only (identity placement)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  upstream state valid
in_ready  output  1  block can accept a state
in_state  input  128  input state, byte k = in_state[127-8k -: 8]
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_state  output  128  result state, same byte ordering
busy  output  1  high in RUN or DONE

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low.
- State layout is column-major: byte k is at row r = k%4, column c = k/4.
- Reset values: in_ready=1, out_valid=0, busy=0, out_state=0, internal counter=0, FSM=IDLE.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, register in_state into the source register, clear the result register, set cnt=0, go to RUN.
  - RUN: in_ready=0. Each cycle:
    - src byte = source byte cnt.
    - dst index = SHIFT_EN ? 4*((c+r)%4)+r : cnt.
    - result[dst] <= InvS(src byte); cnt <= cnt+1.
    - At cnt==15, write the last byte, go to DONE.
  - DONE: out_valid=1, out_state = result register, held stable while out_ready=0. On out_ready, go to IDLE next cycle; out_valid drops.
- Latency: handshake accepted at edge T. RUN occupies edges T+1..T+16. out_valid is high after edge T+16, so first visible in cycle T+17.
- Throughput: one block per 18 cycles minimum, including the IDLE turnaround.
- Counter: 4 bits, wraps 15->0 only on the RUN->DONE transition. Counter is not incremented in IDLE or DONE.
- in_valid while busy: ignored (in_ready=0). Upstream must hold the data.
- out_ready high in IDLE or RUN: no effect.
- out_state holds its value after leaving DONE until the next block's RUN overwrites the bytes. Do not treat out_state as valid unless out_valid=1.
- Reset mid-RUN or mid-DONE: next edge returns to IDLE with reset values. The partial result is discarded and no out_valid pulse is produced.
- Simultaneous rst_n=0 and in_valid=1: reset wins; nothing is captured.
- The S-box path is purely combinational from the source byte mux to the result register write. No extra pipeline stage.

Decomposition:
- Shared AES package holds:
  - State width constant (128) and byte count (16).
  - FSM state encoding (IDLE/RUN/DONE).
  - Function inv_shift_index(k) returning the destination index.
- One sub-module: the team's existing combinational inverse S-box (ISBox), instantiated once.
- Counter, FSM, source/result registers and byte muxes live in this module.

Test Plan:
- FIPS-197 App. C.1 vector: in_state=7ad5fda789ef4e272bca100b3d9ff59f, SHIFT_EN=1, out_ready=1 -> out_state=bd6e7c3df2b5779e0b61216e8b10b689. out_valid is first high exactly 17 cycles after the accept cycle and lasts 1 cycle.
- All-zero input -> out_state=5252...52 (16 bytes). With SHIFT_EN=0 and byte0=0x63, rest 0x00 -> byte0=0x00, all other bytes 0x52.
- Shift placement: SHIFT_EN=1, byte1 (r1,c0)=0x63, rest 0x00 -> out byte5=0x00, all other bytes 0x52.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_state stable. in_ready=0 throughout, and a second in_valid is not captured. Raise out_ready -> one transfer, then in_ready=1.
- Reset mid-operation: rst_n=0 at RUN cycle 7 -> next cycle FSM=IDLE, in_ready=1, out_valid=0, out_state=0. No out_valid pulse follows. A new block afterwards completes correctly.
- Back-to-back: two blocks offered continuously with out_ready=1 -> both results correct and in order, with the second accept occurring one cycle after the first output transfer.

Source files
------------

// File: rtl/inv_sub_shift_serial_pkg.sv
// Shared AES decryption-round definitions: widths, FSM encoding,
// and the InvShiftRows destination mapping.
package inv_sub_shift_serial_pkg;

  localparam int STATE_W = 128;
  localparam int NBYTES  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Byte k sits at row k%4, column k/4; it lands in column (c+r)%4.
  function automatic logic [3:0] inv_shift_index(
    input logic [3:0] k
  );
    logic [1:0] r;
    logic [1:0] c;
    logic [1:0] cn;
    r  = k[1:0];
    c  = k[3:2];
    cn = c + r;
    return {cn, r};
  endfunction

endpackage

// File: rtl/inv_sub_shift_serial_isbox.sv
// Combinational AES inverse S-box.
// Table entry 0 is the most significant byte of the constant.
module inv_sub_shift_serial_isbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  localparam logic [2047:0] TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  logic [10:0] w_off;

  // Offset of entry i_byte counted from the LSB end.
  assign w_off  = {~i_byte, 3'b000};
  assign o_byte = TBL[w_off +: 8];

endmodule

// File: rtl/inv_sub_shift_serial.sv
// Byte-serial InvShiftRows + InvSubBytes stage.
// One inverse S-box is reused over 16 cycles per block.
module inv_sub_shift_serial
  import inv_sub_shift_serial_pkg::*;
#(
  parameter bit SHIFT_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic               busy
);

  state_t             r_state;
  state_t             w_next;
  logic [3:0]         r_cnt;
  logic [STATE_W-1:0] r_src;
  logic [STATE_W-1:0] r_res;

  logic       w_accept;
  logic [3:0] w_dst;
  logic [6:0] w_src_off;
  logic [6:0] w_dst_off;
  logic [7:0] w_src_byte;
  logic [7:0] w_sub_byte;

  // Byte k lives at bits [127-8k -: 8], i.e. offset (15-k)*8.
  assign w_dst      = SHIFT_EN ? inv_shift_index(r_cnt) : r_cnt;
  assign w_src_off  = {~r_cnt, 3'b000};
  assign w_dst_off  = {~w_dst, 3'b000};
  assign w_src_byte = r_src[w_src_off +: 8];
  assign out_state  = r_res;

  inv_sub_shift_serial_isbox u_isbox (
    .i_byte (w_src_byte),
    .o_byte (w_sub_byte)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    w_accept  = 1'b0;
    unique case (1'b1)
      (r_state == IDLE): begin
        in_ready = 1'b1;
        w_accept = in_valid;
        if (in_valid) w_next = RUN;
      end
      (r_state == RUN): begin
        busy = 1'b1;
        if (r_cnt == 4'd15) w_next = DONE;
      end
      (r_state == DONE): begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Source capture, byte counter and result byte writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_src <= '0;
      r_res <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_src <= in_state;
      r_res <= '0;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_res[w_dst_off +: 8] <= w_sub_byte;
      r_cnt <= r_cnt + 4'd1;
    end
  end

endmodule
